counter_nx_mod: RTL

Parametrised, cascadable synchronous counter that generalises the fixed 4-/16-bit T-flip-flop and +1 counters. It adds:
- selectable width and modulus;
- up/down direction;
- wrap, saturate and one-shot modes;
- synchronous load/clear;
- a combinational carry chain and a compare output.

It sits in the timer/prescaler datapath. Several instances chain through CIN/COUT.

---
 rtl/counter_nx_mod_pkg.sv | 20 ++
 rtl/counter_nx_mod_if.sv | 29 ++
 rtl/counter_nx_mod_term.sv | 44 ++++
 rtl/counter_nx_mod.sv | 76 +++++++
 4 files changed

// File: rtl/counter_nx_mod_pkg.sv
// Shared definitions for the counter_nx family: count modes and the MAX helper
// used by this counter and its sibling timer blocks.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // MODULUS of 0 selects the full 2^width range; 64-bit maths keeps width=32 exact.
  function automatic logic [31:0] calcMax(input int unsigned width,
                                          input int unsigned modulus);
    logic [63:0] range;
    range = (modulus == 0) ? (64'd1 << width) : 64'(modulus);
    return 32'(range - 64'd1);
  endfunction

endpackage

// File: rtl/counter_nx_mod_if.sv
// Control/status bundle of one counter_nx_mod stage; master drives the
// controls, the counter itself is the slave.
interface counter_nx_mod_if #(
  parameter int unsigned WIDTH = 16
);
  logic             EN;
  logic             CIN;
  logic             UP;
  logic [1:0]       MODE;
  logic             CLR;
  logic             LOAD;
  logic [WIDTH-1:0] LDVAL;
  logic [WIDTH-1:0] CMPVAL;
  logic [WIDTH-1:0] countVal;
  logic             COUT;
  logic             WRAPP;
  logic             DONE;
  logic             CMP;

  modport master (
    output EN, CIN, UP, MODE, CLR, LOAD, LDVAL, CMPVAL,
    input  countVal, COUT, WRAPP, DONE, CMP
  );

  modport slave (
    input  EN, CIN, UP, MODE, CLR, LOAD, LDVAL, CMPVAL,
    output countVal, COUT, WRAPP, DONE, CMP
  );
endinterface

// File: rtl/counter_nx_mod_term.sv
// Combinational terminal detect, step value and load clamp for one counter
// stage; holds no state.
module counter_nx_term
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MODULUS = 0
) (
  input  logic [WIDTH-1:0] countVal,
  input  logic             up,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] ldVal,
  output logic             term,
  output logic [WIDTH-1:0] stepVal,
  output logic [WIDTH-1:0] ldClamp,
  output logic             wrapEv,
  output logic             doneEv
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(calcMax(WIDTH, MODULUS));
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  always_comb begin
    term    = up ? (countVal == MAXV) : (countVal == '0);
    stepVal = countVal;
    wrapEv  = 1'b0;
    doneEv  = 1'b0;
    if (!term) begin
      stepVal = up ? countVal + ONE : countVal - ONE;
    end else begin
      unique case (mode)
        MODE_SAT:     stepVal = countVal;
        MODE_ONESHOT: doneEv  = 1'b1;
        default: begin
          stepVal = up ? '0 : MAXV;
          wrapEv  = 1'b1;
        end
      endcase
    end
  end

  assign ldClamp = (ldVal > MAXV) ? MAXV : ldVal;

endmodule

// File: rtl/counter_nx_mod.sv
// Cascadable up/down counter with wrap/saturate/one-shot modes, sync
// clear/load, combinational carry-out and registered compare.
module counter_nx_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MODULUS = 0
) (
  input logic               CLK,
  input logic               RESN,
  counter_nx_mod_if.slave   bus
);

  logic [WIDTH-1:0] countQ, countD;
  logic [WIDTH-1:0] stepVal, ldClamp;
  logic             doneQ, doneD;
  logic             wrapQ, wrapD;
  logic             cmpQ;
  logic             term, wrapEv, doneEv, step;

  counter_nx_term #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) uTerm (
    .countVal (countQ),
    .up       (bus.UP),
    .mode     (mode_e'(bus.MODE)),
    .ldVal    (bus.LDVAL),
    .term     (term),
    .stepVal  (stepVal),
    .ldClamp  (ldClamp),
    .wrapEv   (wrapEv),
    .doneEv   (doneEv)
  );

  assign step = bus.EN & bus.CIN & ~doneQ;

  always_comb begin
    countD = countQ;
    doneD  = doneQ;
    wrapD  = 1'b0;
    if (bus.CLR) begin
      countD = '0;
      doneD  = 1'b0;
    end else if (bus.LOAD) begin
      countD = ldClamp;
      doneD  = 1'b0;
    end else if (step) begin
      countD = stepVal;
      doneD  = doneEv;
      wrapD  = wrapEv;
    end
  end

  // CMP compares the next-state value so it lines up with countVal.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      countQ <= '0;
      doneQ  <= 1'b0;
      wrapQ  <= 1'b0;
      cmpQ   <= 1'b0;
    end else begin
      countQ <= countD;
      doneQ  <= doneD;
      wrapQ  <= wrapD;
      cmpQ   <= (countD == bus.CMPVAL);
    end
  end

  assign bus.countVal = countQ;
  assign bus.DONE     = doneQ;
  assign bus.WRAPP    = wrapQ;
  assign bus.CMP      = cmpQ;
  assign bus.COUT     = step & term;

endmodule
